stream_demux2: RTL and testbench

//   Registered 1:2 packet demultiplexer; the counterpart of the 2:1 select mux.

---
 rtl/stream_demux2_if.sv | 21 ++
 rtl/stream_demux2.sv | 150 +++++++++++++++
 tb/tb_stream_demux2.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux2_if.sv
// ============================================================================
// Module     : stream_demux2_if
// Description: Byte-stream valid/ready/last bundle used on both sides of the
//              1:2 packet demultiplexer.
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface stream_demux2_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data;
    logic          valid;
    logic          last;
    logic          ready;

    modport master (output data, output valid, output last, input  ready);
    modport slave  (input  data, input  valid, input  last, output ready);
endinterface

`default_nettype wire

// File: rtl/stream_demux2.sv
// ============================================================================
// Module     : stream_demux2
// Description: Registered 1:2 packet demultiplexer, whole packets routed by
//              explicit select or round-robin. Optional per-channel completed
//              packet counters are enabled by defining DEMUX_CNT_EN.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module stream_demux2 #(
    parameter int DW    = 8
`ifdef DEMUX_CNT_EN
    ,parameter int CNT_W = 16
`endif
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_mode,
    input  wire logic              i_sel,
    stream_demux2_if.slave         i_s,
    stream_demux2_if.master        o_m0,
    stream_demux2_if.master        o_m1,
    output logic                   o_busy
`ifdef DEMUX_CNT_EN
    ,output logic [CNT_W-1:0]      o_cnt0,
    output logic [CNT_W-1:0]       o_cnt1
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_route;
    logic          r_pmode;
    logic          r_rr_ptr;
    logic [DW-1:0] r_d0, r_d1;
    logic          r_v0, r_v1;
    logic          r_l0, r_l1;

    logic          w_first;
    logic          w_tgt;
    logic          w_mode_eff;
    logic          w_rdy;
    logic          w_acc;
    logic          w_fill0, w_fill1;

    // Target and mode are sampled only on the first beat; later beats reuse the latched copies.
    assign w_first    = (r_state == IDLE);
    assign w_mode_eff = w_first ? i_mode : r_pmode;
    assign w_tgt      = w_first ? (i_mode ? r_rr_ptr : i_sel) : r_route;
    assign w_rdy      = w_tgt ? (~r_v1 | o_m1.ready) : (~r_v0 | o_m0.ready);
    assign i_s.ready  = rst_n & w_rdy;
    assign w_acc      = i_s.valid & i_s.ready;
    assign w_fill0    = w_acc & ~w_tgt;
    assign w_fill1    = w_acc &  w_tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_acc && !i_s.last) w_state_nxt = PKT;
            PKT:     if (w_acc &&  i_s.last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_route  <= 1'b0;
            r_pmode  <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else if (w_acc) begin
            if (w_first) begin
                r_route <= w_tgt;
                r_pmode <= i_mode;
            end
            if (i_s.last && w_mode_eff) begin
                r_rr_ptr <= ~r_rr_ptr;
            end
        end
    end

    // Each output register refills on the same edge it drains, giving full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
            r_d0 <= '0;
            r_l0 <= 1'b0;
        end else if (w_fill0) begin
            r_v0 <= 1'b1;
            r_d0 <= i_s.data;
            r_l0 <= i_s.last;
        end else if (o_m0.ready) begin
            r_v0 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
            r_l1 <= 1'b0;
        end else if (w_fill1) begin
            r_v1 <= 1'b1;
            r_d1 <= i_s.data;
            r_l1 <= i_s.last;
        end else if (o_m1.ready) begin
            r_v1 <= 1'b0;
        end
    end

    assign o_m0.data  = r_d0;
    assign o_m0.valid = r_v0;
    assign o_m0.last  = r_l0;
    assign o_m1.data  = r_d1;
    assign o_m1.valid = r_v1;
    assign o_m1.last  = r_l1;
    assign o_busy     = (r_state == PKT);

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt0, r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (r_v0 && r_l0 && o_m0.ready) r_cnt0 <= r_cnt0 + 1'b1;
            if (r_v1 && r_l1 && o_m1.ready) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign o_cnt0 = r_cnt0;
    assign o_cnt1 = r_cnt1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_demux2.sv
// ============================================================================
// Module     : tb_stream_demux2
// Description: Directed self-checking bench for stream_demux2 (counter checks
//              only when DEMUX_CNT_EN is defined).
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_stream_demux2;

    logic clk;
    logic rst_n;
    logic mode;
    logic sel;
    logic busy;
    int   n_tot;
    int   n_bad;

    stream_demux2_if #(.DW(8)) s_in ();
    stream_demux2_if #(.DW(8)) m0 ();
    stream_demux2_if #(.DW(8)) m1 ();

`ifdef DEMUX_CNT_EN
    logic [1:0] cnt0, cnt1;
    stream_demux2 #(.DW(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_mode(mode), .i_sel(sel),
        .i_s(s_in), .o_m0(m0), .o_m1(m1), .o_busy(busy),
        .o_cnt0(cnt0), .o_cnt1(cnt1)
    );
`else
    stream_demux2 #(.DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_mode(mode), .i_sel(sel),
        .i_s(s_in), .o_m0(m0), .o_m1(m1), .o_busy(busy)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [7:0] d, input logic l);
        s_in.valid = v;
        s_in.data  = d;
        s_in.last  = l;
    endtask

    initial begin
        n_tot = 0;
        n_bad = 0;
        rst_n = 1'b0;
        mode  = 1'b0;
        sel   = 1'b0;
        drv(1'b0, 8'h00, 1'b0);
        m0.ready = 1'b1;
        m1.ready = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, s_in.ready}, 32'd0);
        cyc(); cyc();
        chk("rst_v0", {31'd0, m0.valid}, 32'd0);
        chk("rst_v1", {31'd0, m1.valid}, 32'd0);
        chk("rst_d0", {24'd0, m0.data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;

        // 1: explicit select to channel 1, three beats
        sel = 1'b1;
        drv(1'b1, 8'hA1, 1'b0);
        cyc();
        chk("t1_d_a1", {24'd0, m1.data}, 32'hA1);
        chk("t1_v1", {31'd0, m1.valid}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        drv(1'b1, 8'hA2, 1'b0);
        cyc();
        chk("t1_d_a2", {24'd0, m1.data}, 32'hA2);
        chk("t1_l_a2", {31'd0, m1.last}, 32'd0);
        drv(1'b1, 8'hA3, 1'b1);
        cyc();
        chk("t1_d_a3", {24'd0, m1.data}, 32'hA3);
        chk("t1_l_a3", {31'd0, m1.last}, 32'd1);
        chk("t1_v0", {31'd0, m0.valid}, 32'd0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        drv(1'b0, 8'h00, 1'b0);
        cyc();
        chk("t1_drain", {31'd0, m1.valid}, 32'd0);

        // 2: round-robin over four single-beat packets
        mode = 1'b1;
        drv(1'b1, 8'h11, 1'b1);
        cyc();
        chk("t2_d0_11", {24'd0, m0.data}, 32'h11);
        chk("t2_v1_a", {31'd0, m1.valid}, 32'd0);
        drv(1'b1, 8'h22, 1'b1);
        cyc();
        chk("t2_d1_22", {24'd0, m1.data}, 32'h22);
        chk("t2_v0_b", {31'd0, m0.valid}, 32'd0);
        drv(1'b1, 8'h33, 1'b1);
        cyc();
        chk("t2_d0_33", {24'd0, m0.data}, 32'h33);
        chk("t2_v0_c", {31'd0, m0.valid}, 32'd1);
        drv(1'b1, 8'h44, 1'b1);
        cyc();
        chk("t2_d1_44", {24'd0, m1.data}, 32'h44);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        drv(1'b0, 8'h00, 1'b0);
        cyc();

        // 3: channel 0 backpressure
        mode = 1'b0;
        sel  = 1'b0;
        m0.ready = 1'b0;
        drv(1'b1, 8'hB1, 1'b0);
        cyc();
        chk("t3_d_b1", {24'd0, m0.data}, 32'hB1);
        drv(1'b1, 8'hB2, 1'b0);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_rdy_low", {31'd0, s_in.ready}, 32'd0);
            chk("t3_hold", {24'd0, m0.data}, 32'hB1);
            cyc();
        end
        m0.ready = 1'b1;
        #1;
        chk("t3_rdy_back", {31'd0, s_in.ready}, 32'd1);
        cyc();
        chk("t3_d_b2", {24'd0, m0.data}, 32'hB2);
        drv(1'b1, 8'hB3, 1'b1);
        cyc();
        chk("t3_d_b3", {24'd0, m0.data}, 32'hB3);
        chk("t3_l_b3", {31'd0, m0.last}, 32'd1);
        drv(1'b0, 8'h00, 1'b0);
        cyc();
        chk("t3_drain", {31'd0, m0.valid}, 32'd0);

        // 4: select toggled mid-packet must not split the packet
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 8'hD1 + 8'(i), (i == 3));
            cyc();
            sel = 1'b0;
            chk("t4_data", {24'd0, m1.data}, 32'hD1 + 32'(i));
            chk("t4_v0", {31'd0, m0.valid}, 32'd0);
            chk("t4_busy", {31'd0, busy}, (i == 3) ? 32'd0 : 32'd1);
        end
        drv(1'b0, 8'h00, 1'b0);
        cyc();

        // 5: reset in the middle of a packet held on channel 1
        mode = 1'b1;
        drv(1'b1, 8'h5A, 1'b1);
        cyc();
        chk("t5_pre_ch0", {24'd0, m0.data}, 32'h5A);
        m1.ready = 1'b0;
        drv(1'b1, 8'h5B, 1'b0);
        cyc();
        chk("t5_v1_set", {31'd0, m1.valid}, 32'd1);
        chk("t5_busy_set", {31'd0, busy}, 32'd1);
        drv(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_v1_rst", {31'd0, m1.valid}, 32'd0);
        chk("t5_d1_rst", {24'd0, m1.data}, 32'd0);
        chk("t5_busy_rst", {31'd0, busy}, 32'd0);
        chk("t5_rdy_rst", {31'd0, s_in.ready}, 32'd0);
        cyc();
        rst_n = 1'b1;
        m1.ready = 1'b1;
        drv(1'b1, 8'h55, 1'b1);
        cyc();
        chk("t5_post_ch0", {24'd0, m0.data}, 32'h55);
        chk("t5_post_v0", {31'd0, m0.valid}, 32'd1);
        chk("t5_post_v1", {31'd0, m1.valid}, 32'd0);
        drv(1'b0, 8'h00, 1'b0);
        cyc();

`ifdef DEMUX_CNT_EN
        // 6: counter wrap with a 2-bit counter
        rst_n = 1'b0;
        #1;
        cyc();
        rst_n = 1'b1;
        mode = 1'b0;
        sel  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 8'h60 + 8'(i), 1'b1);
            cyc();
        end
        drv(1'b0, 8'h00, 1'b0);
        cyc();
        chk("t6_cnt0", {30'd0, cnt0}, 32'd1);
        chk("t6_cnt1", {30'd0, cnt1}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
